// File: rtl/div_sched.sv
// Programmable integer clock-enable divider with a tick pulse and a divided phase waveform.
// A ratio change requested while running is deferred to the next period boundary.
module div_sched #(
  parameter int CNT_WIDTH = 8,
  parameter int DEF_DIV   = 4
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 div_en,
  input  logic                 cfg_valid,
  input  logic [CNT_WIDTH-1:0] cfg_div,
  output logic                 cfg_ready,
  input  logic                 err_clr,
  output logic                 tick,
  output logic                 phase,
  output logic [CNT_WIDTH-1:0] cur_div,
  output logic                 busy,
  output logic                 err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] DEF_RATIO = CNT_WIDTH'(DEF_DIV);
  localparam logic [CNT_WIDTH-1:0] MIN_RATIO = CNT_WIDTH'(2);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] cur_div_q, cur_div_d;
  logic [CNT_WIDTH-1:0] pend_div_q, pend_div_d;
  logic                 err_q, err_d;

  logic                 active;
  logic                 at_wrap;
  logic [CNT_WIDTH-1:0] high_len;
  logic                 cfg_accept;
  logic                 cfg_legal;
  logic                 cfg_illegal;

  // cur_div_q is never below 2, so cur_div_q - 1 cannot underflow.
  assign active      = (state_q != IDLE);
  assign at_wrap     = (cnt_q == (cur_div_q - 1'b1));
  assign high_len    = (cur_div_q >> 1) + {{(CNT_WIDTH-1){1'b0}}, cur_div_q[0]};
  assign cfg_accept  = cfg_valid && cfg_ready;
  assign cfg_legal   = cfg_accept && (cfg_div >= MIN_RATIO);
  assign cfg_illegal = cfg_accept && (cfg_div < MIN_RATIO);

  assign cfg_ready = (state_q != PEND);
  assign busy      = (state_q == PEND);
  assign tick      = active && at_wrap;
  assign phase     = active && (cnt_q < high_len);
  assign cur_div   = cur_div_q;
  assign err       = err_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_div_d  = cur_div_q;
    pend_div_d = pend_div_q;
    err_d      = err_q;

    // An illegal request landing together with a clear keeps the flag set.
    if (err_clr) begin
      err_d = 1'b0;
    end
    if (cfg_illegal) begin
      err_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (cfg_legal) begin
          cur_div_d = cfg_div;
        end
        if (div_en) begin
          state_d = RUN;
        end
      end

      RUN: begin
        if (!div_en) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (cfg_legal) begin
            cur_div_d = cfg_div;
          end
        end else begin
          cnt_d = at_wrap ? '0 : cnt_q + 1'b1;
          if (cfg_legal) begin
            pend_div_d = cfg_div;
            state_d    = PEND;
          end
        end
      end

      PEND: begin
        // The boundary tick itself still belongs to the old ratio.
        if (!div_en || at_wrap) begin
          cur_div_d = pend_div_q;
          cnt_d     = '0;
          state_d   = div_en ? RUN : IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cur_div_q  <= DEF_RATIO;
      pend_div_q <= DEF_RATIO;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_div_q  <= cur_div_d;
      pend_div_q <= pend_div_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_div_sched.sv
// Directed self-checking bench for div_sched: default run, IDLE/RUN/PEND ratio changes,
// illegal ratios, disable with pending update, and reset during PEND.
module tb_div_sched;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       div_en = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_div = 8'd0;
  logic       cfg_ready;
  logic       err_clr = 1'b0;
  logic       tick;
  logic       phase;
  logic [7:0] cur_div;
  logic       busy;
  logic       err;

  int tests_run = 0;
  int tests_failed = 0;

  div_sched #(.CNT_WIDTH(8), .DEF_DIV(4)) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .div_en   (div_en),
    .cfg_valid(cfg_valid),
    .cfg_div  (cfg_div),
    .cfg_ready(cfg_ready),
    .err_clr  (err_clr),
    .tick     (tick),
    .phase    (phase),
    .cur_div  (cur_div),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk_in = ~clk_in;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    div_en = 1'b0;
    cfg_valid = 1'b0;
    err_clr = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (cur_div !== 8'd4) begin
      tests_failed++;
      $display("[TB] FAIL reset_cur_div got %0d want 4", cur_div);
    end
    tests_run++;
    if ({tick, phase, cfg_ready, busy, err} !== 5'b00100) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags got %b want 00100", {tick, phase, cfg_ready, busy, err});
    end
  endtask

  task automatic test_default_run();
    div_en = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if ({tick, phase} !== {(i % 4) == 3, (i % 4) < 2}) begin
        tests_failed++;
        $display("[TB] FAIL default_run[%0d] tick/phase got %b%b want %b%b", i, tick, phase,
                 (i % 4) == 3, (i % 4) < 2);
      end
      if (i < 7) step();
    end
    div_en = 1'b0;
    step();
    tests_run++;
    if ({tick, phase, busy} !== 3'b000 || cur_div !== 8'd4) begin
      tests_failed++;
      $display("[TB] FAIL default_stop got tpb=%b div=%0d want 000 div=4", {tick, phase, busy}, cur_div);
    end
  endtask

  task automatic test_cfg_idle();
    cfg_valid = 1'b1;
    cfg_div = 8'd5;
    step();
    cfg_valid = 1'b0;
    tests_run++;
    if (cur_div !== 8'd5 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL cfg_idle_load got div=%0d busy=%b want 5 0", cur_div, busy);
    end
    div_en = 1'b1;
    step();
    for (int i = 0; i < 10; i++) begin
      tests_run++;
      if ({tick, phase} !== {(i % 5) == 4, (i % 5) < 3}) begin
        tests_failed++;
        $display("[TB] FAIL cfg_idle_run[%0d] tick/phase got %b%b want %b%b", i, tick, phase,
                 (i % 5) == 4, (i % 5) < 3);
      end
      if (i < 9) step();
    end
    div_en = 1'b0;
    step();
  endtask

  task automatic test_pending();
    do_reset();
    div_en = 1'b1;
    step();
    step();
    cfg_valid = 1'b1;
    cfg_div = 8'd3;
    step();
    cfg_valid = 1'b0;
    tests_run++;
    if ({busy, cfg_ready, tick} !== 3'b100 || cur_div !== 8'd4) begin
      tests_failed++;
      $display("[TB] FAIL pend_enter got brt=%b div=%0d want 100 div=4", {busy, cfg_ready, tick}, cur_div);
    end
    step();
    tests_run++;
    if ({busy, cfg_ready, tick} !== 3'b101 || cur_div !== 8'd4) begin
      tests_failed++;
      $display("[TB] FAIL pend_boundary got brt=%b div=%0d want 101 div=4", {busy, cfg_ready, tick}, cur_div);
    end
    step();
    tests_run++;
    if ({busy, cfg_ready} !== 2'b01 || cur_div !== 8'd3) begin
      tests_failed++;
      $display("[TB] FAIL pend_apply got br=%b div=%0d want 01 div=3", {busy, cfg_ready}, cur_div);
    end
    for (int i = 0; i < 6; i++) begin
      tests_run++;
      if ({tick, phase} !== {(i % 3) == 2, (i % 3) < 2}) begin
        tests_failed++;
        $display("[TB] FAIL pend_newrate[%0d] tick/phase got %b%b want %b%b", i, tick, phase,
                 (i % 3) == 2, (i % 3) < 2);
      end
      if (i < 5) step();
    end
  endtask

  task automatic test_back_to_back();
    // Request lands exactly on a tick of N=3 and must wait a full period.
    cfg_valid = 1'b1;
    cfg_div = 8'd4;
    step();
    cfg_valid = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || cur_div !== 8'd3 || phase !== 1'b1 || tick !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_deferred got busy=%b div=%0d ph=%b tk=%b want 1 3 1 0", busy, cur_div, phase, tick);
    end
    step();
    step();
    tests_run++;
    if (tick !== 1'b1 || busy !== 1'b1 || cur_div !== 8'd3) begin
      tests_failed++;
      $display("[TB] FAIL b2b_old_tick got tick=%b busy=%b div=%0d want 1 1 3", tick, busy, cur_div);
    end
    step();
    tests_run++;
    if (busy !== 1'b0 || cur_div !== 8'd4) begin
      tests_failed++;
      $display("[TB] FAIL b2b_apply got busy=%b div=%0d want 0 4", busy, cur_div);
    end
  endtask

  task automatic test_illegal();
    cfg_valid = 1'b1;
    cfg_div = 8'd1;
    step();
    cfg_valid = 1'b0;
    tests_run++;
    if (err !== 1'b1 || busy !== 1'b0 || cur_div !== 8'd4) begin
      tests_failed++;
      $display("[TB] FAIL illegal_set got err=%b busy=%b div=%0d want 1 0 4", err, busy, cur_div);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    tests_run++;
    if (err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL illegal_clear got err=%b want 0", err);
    end
    cfg_valid = 1'b1;
    cfg_div = 8'd0;
    err_clr = 1'b1;
    step();
    cfg_valid = 1'b0;
    err_clr = 1'b0;
    tests_run++;
    if (err !== 1'b1 || cur_div !== 8'd4) begin
      tests_failed++;
      $display("[TB] FAIL illegal_vs_clear got err=%b div=%0d want 1 4", err, cur_div);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
  endtask

  task automatic test_drop_pending();
    do_reset();
    div_en = 1'b1;
    step();
    step();
    cfg_valid = 1'b1;
    cfg_div = 8'd6;
    step();
    cfg_valid = 1'b0;
    div_en = 1'b0;
    step();
    tests_run++;
    if ({tick, phase, busy} !== 3'b000 || cur_div !== 8'd6) begin
      tests_failed++;
      $display("[TB] FAIL drop_idle got tpb=%b div=%0d want 000 div=6", {tick, phase, busy}, cur_div);
    end
    div_en = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      tests_run++;
      if ({tick, phase} !== {i == 5, i < 3}) begin
        tests_failed++;
        $display("[TB] FAIL drop_restart[%0d] tick/phase got %b%b want %b%b", i, tick, phase, i == 5, i < 3);
      end
      if (i < 5) step();
    end
  endtask

  task automatic test_en_with_cfg();
    div_en = 1'b0;
    step();
    div_en = 1'b1;
    cfg_valid = 1'b1;
    cfg_div = 8'd2;
    step();
    cfg_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if ({tick, phase} !== {(i % 2) == 1, (i % 2) == 0} || cur_div !== 8'd2) begin
        tests_failed++;
        $display("[TB] FAIL en_cfg[%0d] got tk=%b ph=%b div=%0d want %b %b 2", i, tick, phase, cur_div,
                 (i % 2) == 1, (i % 2) == 0);
      end
      if (i < 3) step();
    end
  endtask

  task automatic test_rst_in_pend();
    cfg_valid = 1'b1;
    cfg_div = 8'd0;
    step();
    cfg_div = 8'd7;
    step();
    tests_run++;
    if (busy !== 1'b1 || err !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL rstpend_setup got busy=%b err=%b want 1 1", busy, err);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    cfg_valid = 1'b0;
    div_en = 1'b0;
    tests_run++;
    if (cur_div !== 8'd4 || {busy, err, tick, phase, cfg_ready} !== 5'b00001) begin
      tests_failed++;
      $display("[TB] FAIL rstpend_state got div=%0d betpr=%b want 4 00001", cur_div,
               {busy, err, tick, phase, cfg_ready});
    end
    step();
    tests_run++;
    if (cur_div !== 8'd4 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rstpend_discard got div=%0d busy=%b want 4 0", cur_div, busy);
    end
  endtask

  initial begin
    test_reset();
    test_default_run();
    test_cfg_idle();
    test_pending();
    test_back_to_back();
    test_illegal();
    test_drop_pending();
    test_en_with_cfg();
    test_rst_in_pend();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/div_sched.md
DIV_SCHED -- requirements
Module: div_sched

Interface
REQ-001 The parameter list SHALL be: CNT_WIDTH, default 8, counter and ratio bit width.
REQ-002 The parameter list SHALL include: DEF_DIV, default 4, ratio loaded at reset; legal range 2..2^CNT_WIDTH-1.
REQ-003 Port clk_in SHALL be: input, 1 bit, the single clock; all logic rising-edge.
REQ-004 Port rst SHALL be: input, 1 bit; reset is synchronous and active-high.
REQ-005 Port div_en SHALL be: input, 1 bit, run enable for the divider.
REQ-006 Port cfg_valid SHALL be: input, 1 bit, new-ratio request.
REQ-007 Port cfg_div SHALL be: input, CNT_WIDTH bits, requested ratio N.
REQ-008 Port cfg_ready SHALL be: output, 1 bit, able to accept a request.
REQ-009 Port err_clr SHALL be: input, 1 bit, clears err.
REQ-010 Port tick SHALL be: output, 1 bit, one-cycle pulse on the last cycle of each period.
REQ-011 Port phase SHALL be: output, 1 bit, divided waveform.
REQ-012 Port cur_div SHALL be: output, CNT_WIDTH bits, ratio in effect.
REQ-013 Port busy SHALL be: output, 1 bit, an update is pending.
REQ-014 Port err SHALL be: output, 1 bit, sticky illegal-ratio flag.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and PEND (running with an update pending).
REQ-016 Counter cnt SHALL count 0..cur_div-1 in RUN/PEND, wrap to 0 after cur_div-1, and be held at 0 in IDLE.
REQ-017 From IDLE with div_en=1 sampled at edge k, the block SHALL enter RUN; cnt=0 in cycle k+1 and the first tick falls in cycle k+cur_div.
REQ-018 tick SHALL be 1 exactly when state!=IDLE and cnt==cur_div-1 (decoded from registers, no added latency).
REQ-019 phase SHALL be 1 when state!=IDLE and cnt<ceil(cur_div/2), else 0; odd N gives high for (N+1)/2 cycles and low for (N-1)/2 cycles.
REQ-020 cfg_ready SHALL be 1 in IDLE and RUN and 0 in PEND; a request is accepted when cfg_valid&&cfg_ready at a rising edge.
REQ-021 An accepted cfg_div<2 SHALL be discarded, set err=1 on the next cycle, and leave state and cur_div unchanged.
REQ-022 An accepted legal request in IDLE SHALL update cur_div on the next cycle.
REQ-023 An accepted legal request in RUN SHALL latch a pending ratio, enter PEND and set busy=1.
REQ-024 In PEND, on the cycle where cnt==cur_div-1, the block SHALL load cur_div with the pending ratio, set cnt to 0, clear busy and return to RUN; the tick at that boundary uses the old ratio.
REQ-025 A request accepted in RUN in the same cycle as cnt==cur_div-1 SHALL wait for the following boundary and SHALL NOT apply immediately.
REQ-026 div_en=0 in RUN or PEND SHALL force IDLE on the next cycle, with cnt=0 and tick=phase=0; any pending ratio SHALL load into cur_div at that same edge and busy SHALL clear.
REQ-027 div_en=1 with cfg_valid in IDLE in the same cycle SHALL apply the new ratio to the first period.
REQ-028 err_clr SHALL clear err on the next cycle; if it coincides with an illegal accept, err SHALL stay 1.
REQ-029 cur_div SHALL never hold a value <2.

Reset
REQ-030 With rst=1 at an edge, the block SHALL set state=IDLE, cnt=0, cur_div=DEF_DIV, tick=0, phase=0, cfg_ready=1, busy=0, err=0, and discard any pending ratio.
REQ-031 rst SHALL take priority over div_en, cfg_valid and err_clr, including during PEND mid-period.

Verification
REQ-032 Scenario: reset, div_en=1 held, DEF_DIV=4 -> tick every 4th cycle; phase 1,1,0,0 repeating; cur_div=4.
REQ-033 Scenario: cfg_div=5 accepted in IDLE, then run -> period 5; phase high 3 and low 2; tick on each cnt=4.
REQ-034 Scenario: running N=4, cfg_div=3 accepted at cnt=1 -> busy=1 and cfg_ready=0 until the cnt=3 tick; the next periods are 3 cycles; busy=0.
REQ-035 Scenario: cfg_div=1 accepted -> err=1, cur_div unchanged, no busy; err_clr pulse -> err=0.
REQ-036 Scenario: div_en dropped at cnt=2 of N=4 with pending 6 -> next cycle tick=0, phase=0, cur_div=6; re-enable gives first tick 6 cycles later.
REQ-037 Scenario: rst asserted during PEND -> next cycle cur_div=DEF_DIV, busy=0, err=0, state IDLE.
